// File: rtl/wb_stage_pipe_if.sv
// wb_stage_pipe_if: MEM->WB capture bus and writeback/forwarding outputs of wb_stage_pipe.
interface wb_stage_pipe_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
);
  localparam int AW = $clog2(XLEN / 8);
  logic              in_valid;
  logic              in_RegWrite;
  logic [1:0]        in_ResultSrc;
  logic [2:0]        in_funct3;
  logic [AW-1:0]     in_addr_lo;
  logic [REG_AW-1:0] in_rd;
  logic [XLEN-1:0]   in_alu_output;
  logic [XLEN-1:0]   in_mem_data;
  logic [XLEN-1:0]   in_pc_plus4;
  logic              stall;
  logic              flush;
  logic              wb_valid;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   write_data;
  logic              load_misaligned;
  logic [CNT_W-1:0]  retire_count;
  modport master (
    output in_valid, in_RegWrite, in_ResultSrc, in_funct3, in_addr_lo, in_rd,
           in_alu_output, in_mem_data, in_pc_plus4, stall, flush,
    input  wb_valid, wb_RegWrite, wb_rd, write_data, load_misaligned, retire_count
  );
  modport slave (
    input  in_valid, in_RegWrite, in_ResultSrc, in_funct3, in_addr_lo, in_rd,
           in_alu_output, in_mem_data, in_pc_plus4, stall, flush,
    output wb_valid, wb_RegWrite, wb_rd, write_data, load_misaligned, retire_count
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered MEM/WB stage with load extraction and writeback mux.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input logic           clk,
  input logic           reset,
  wb_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(XLEN / 8);
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [1:0]        src;
    logic [2:0]        funct3;
    logic [AW-1:0]     addr_lo;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   mem;
    logic [XLEN-1:0]   pc4;
    logic              mis;
  } stage_t;
  stage_t          stage_d, stage_q;
  logic [3:0]      size_mask;
  logic [XLEN-1:0] sh, load;
  logic            ill;
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int w, input logic s);
    logic        [XLEN-1:0] t;
    logic signed [XLEN-1:0] a;
    t = v << (XLEN - w);
    a = $signed(t) >>> (XLEN - w);
    if (s) return a;
    return t >> (XLEN - w);
  endfunction
  always_comb begin
    size_mask = (4'd1 << bus.in_funct3[1:0]) - 4'd1;
    stage_d   = stage_q;
    if (bus.flush) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mis       = 1'b0;
    end else if (!bus.stall) begin
      stage_d = '{valid: bus.in_valid, reg_write: bus.in_RegWrite, src: bus.in_ResultSrc,
                  funct3: bus.in_funct3, addr_lo: bus.in_addr_lo, rd: bus.in_rd,
                  alu: bus.in_alu_output, mem: bus.in_mem_data, pc4: bus.in_pc_plus4,
                  mis: bus.in_ResultSrc == 2'b01 && |(bus.in_addr_lo & size_mask[AW-1:0])};
    end
  end
  always_ff @(posedge clk)
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  // Extraction works on the registered word so the raw memory path stays off the capture edge.
  always_comb begin
    sh   = stage_q.mem >> {stage_q.addr_lo, 3'b000};
    ill  = stage_q.src == 2'b01 && (stage_q.funct3 == 3'b111 ||
           (XLEN == 32 && (stage_q.funct3 == 3'b011 || stage_q.funct3 == 3'b110)));
    load = stage_q.funct3 == 3'b000 ? ext(sh, 8, 1'b1)  :
           stage_q.funct3 == 3'b001 ? ext(sh, 16, 1'b1) :
           stage_q.funct3 == 3'b010 ? ext(sh, 32, 1'b1) :
           stage_q.funct3 == 3'b011 ? sh                :
           stage_q.funct3 == 3'b100 ? ext(sh, 8, 1'b0)  :
           stage_q.funct3 == 3'b101 ? ext(sh, 16, 1'b0) :
           stage_q.funct3 == 3'b110 ? ext(sh, 32, 1'b0) : '0;
  end
  assign bus.wb_valid        = stage_q.valid;
  assign bus.wb_rd           = stage_q.rd;
  assign bus.load_misaligned = stage_q.mis;
  assign bus.write_data      = stage_q.src == 2'b00 ? stage_q.alu :
                               stage_q.src == 2'b01 ? (ill ? '0 : load) :
                               stage_q.src == 2'b10 ? stage_q.pc4 : '0;
  assign bus.wb_RegWrite     = stage_q.valid & stage_q.reg_write & (stage_q.rd != '0) &
                               ~ill & ~stage_q.mis & (stage_q.src != 2'b11);
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = cnt_q + CNT_W'(stage_q.valid & ~bus.stall);
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign bus.retire_count = cnt_q;
`else
  assign bus.retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: directed vectors for wb_stage_pipe; define WB_RETIRE_CNT_EN to check the counter at CNT_W=4.
module tb_wb_stage_pipe;
`ifdef WB_RETIRE_CNT_EN
  localparam int  CW     = 4;
  localparam bit  CNT_EN = 1'b1;
`else
  localparam int  CW     = 64;
  localparam bit  CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0, n_pass = 0;
  wb_stage_pipe_if #(.XLEN(64), .REG_AW(5), .CNT_W(CW)) bus ();
  wb_stage_pipe #(.XLEN(64), .REG_AW(5), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [2:0] a, input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] mem, input logic [63:0] pc4);
    bus.in_valid = v; bus.in_RegWrite = rw; bus.in_ResultSrc = src; bus.in_funct3 = f3;
    bus.in_addr_lo = a; bus.in_rd = rd; bus.in_alu_output = alu; bus.in_mem_data = mem;
    bus.in_pc_plus4 = pc4;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd3, 64'h55, 64'h0, 64'h0);
    step(); step();
    chk("rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_rw", 64'(bus.wb_RegWrite), 64'd0);
    chk("rst_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_wd", bus.write_data, 64'd0);
    chk("rst_mis", 64'(bus.load_misaligned), 64'd0);
    chk("rst_cnt", 64'(bus.retire_count), 64'd0);
    reset = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd5, 64'h1234, 64'h0, 64'h0); step();
    chk("alu_wd", bus.write_data, 64'h1234);
    chk("alu_rw", 64'(bus.wb_RegWrite), 64'd1);
    chk("alu_rd", 64'(bus.wb_rd), 64'd5);
    chk("alu_valid", 64'(bus.wb_valid), 64'd1);
    drive(1, 1, 2'b01, 3'b000, 3'd2, 5'd6, 64'h0, 64'h0000_0000_0080_0000, 64'h0); step();
    chk("lb_wd", bus.write_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_rw", 64'(bus.wb_RegWrite), 64'd1);
    drive(1, 1, 2'b01, 3'b100, 3'd2, 5'd6, 64'h0, 64'h0000_0000_0080_0000, 64'h0); step();
    chk("lbu_wd", bus.write_data, 64'h80);
    drive(1, 1, 2'b01, 3'b010, 3'd2, 5'd6, 64'h0, 64'h0000_0000_0080_0000, 64'h0); step();
    chk("lw_mis", 64'(bus.load_misaligned), 64'd1);
    chk("lw_mis_rw", 64'(bus.wb_RegWrite), 64'd0);
    drive(1, 1, 2'b01, 3'b001, 3'd6, 5'd6, 64'h0, 64'h8001_0000_0000_0000, 64'h0); step();
    chk("lh_wd", bus.write_data, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_mis", 64'(bus.load_misaligned), 64'd0);
    chk("lh_rw", 64'(bus.wb_RegWrite), 64'd1);
    drive(1, 1, 2'b01, 3'b110, 3'd4, 5'd6, 64'h0, 64'h8000_0000_1234_5678, 64'h0); step();
    chk("lwu_wd", bus.write_data, 64'h0000_0000_8000_0000);
    drive(1, 1, 2'b01, 3'b010, 3'd4, 5'd6, 64'h0, 64'h8000_0000_1234_5678, 64'h0); step();
    chk("lw_wd", bus.write_data, 64'hFFFF_FFFF_8000_0000);
    drive(1, 1, 2'b01, 3'b011, 3'd0, 5'd6, 64'h0, 64'hDEAD_BEEF_0123_4567, 64'h0); step();
    chk("ld_wd", bus.write_data, 64'hDEAD_BEEF_0123_4567);
    drive(1, 1, 2'b01, 3'b011, 3'd4, 5'd6, 64'h0, 64'hDEAD_BEEF_0123_4567, 64'h0); step();
    chk("ld_mis", 64'(bus.load_misaligned), 64'd1);
    drive(1, 1, 2'b01, 3'b111, 3'd0, 5'd6, 64'h0, 64'hDEAD_BEEF_0123_4567, 64'h0); step();
    chk("ill_wd", bus.write_data, 64'd0);
    chk("ill_rw", 64'(bus.wb_RegWrite), 64'd0);
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd0, 64'h1234, 64'h0, 64'h0); step();
    chk("rd0_rw", 64'(bus.wb_RegWrite), 64'd0);
    drive(1, 1, 2'b10, 3'b000, 3'd0, 5'd1, 64'h1234, 64'h0, 64'h104); step();
    chk("pc4_wd", bus.write_data, 64'h104);
    chk("pc4_rw", 64'(bus.wb_RegWrite), 64'd1);
    drive(1, 1, 2'b11, 3'b000, 3'd0, 5'd1, 64'h1234, 64'h0, 64'h104); step();
    chk("rsv_wd", bus.write_data, 64'd0);
    chk("rsv_rw", 64'(bus.wb_RegWrite), 64'd0);
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd7, 64'hAAAA, 64'h0, 64'h0); step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, 3'b000, 3'd0, 5'(9 + i), 64'hBBBB, 64'h0, 64'h200); step();
      chk("stall_wd", bus.write_data, 64'hAAAA);
      chk("stall_rd", 64'(bus.wb_rd), 64'd7);
    end
    bus.flush = 1'b1; step();
    chk("flush_valid", 64'(bus.wb_valid), 64'd0);
    chk("flush_rw", 64'(bus.wb_RegWrite), 64'd0);
    bus.flush = 1'b0; bus.stall = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd8, 64'hCCCC, 64'h0, 64'h0); step();
    chk("resume_wd", bus.write_data, 64'hCCCC);
    drive(1, 1, 2'b01, 3'b010, 3'd2, 5'd8, 64'h0, 64'h0, 64'h0); reset = 1'b1; step();
    chk("mid_rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("mid_rst_wd", bus.write_data, 64'd0);
    chk("mid_rst_rd", 64'(bus.wb_rd), 64'd0);
    chk("mid_rst_mis", 64'(bus.load_misaligned), 64'd0);
    chk("mid_rst_cnt", 64'(bus.retire_count), 64'd0);
    reset = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 3'd0, 5'd4, 64'h1, 64'h0, 64'h0);
    for (int i = 0; i < 17; i++) step();
    chk("cnt_16", 64'(bus.retire_count), 64'd0);
    bus.in_valid = 1'b0; step();
    chk("cnt_wrap", 64'(bus.retire_count), CNT_EN ? 64'd1 : 64'd0);
    bus.in_valid = 1'b1; step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_stall", 64'(bus.retire_count), CNT_EN ? 64'd1 : 64'd0);
    bus.stall = 1'b0; bus.in_valid = 1'b0; step();
    chk("cnt_resume", 64'(bus.retire_count), CNT_EN ? 64'd2 : 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
